sequential_divider: RTL and testbench

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/divider_pkg.sv | 18 +
 rtl/div_step.sv | 16 +
 rtl/sequential_divider.sv | 134 +++++++++++++
 tb/tb_sequential_divider.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider: FSM state type and sizing helpers.
package divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // The counter must be able to hold WIDTH itself, which it reaches on leaving CALC.
  function automatic int div_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  // rem_i < 2*divisor, so after a successful subtract the result fits in WIDTH bits
  // and the low WIDTH bits of a modular subtract are exact.
  assign q_bit_o = (rem_i >= {1'b0, divisor_i});
  assign rem_o   = q_bit_o ? (rem_i[WIDTH-1:0] - divisor_i) : rem_i[WIDTH-1:0];

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle signed/unsigned divider: one quotient bit per clock, then sign fix-up.
module sequential_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_width(WIDTH);

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (-v) : v;
  endfunction

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] prem_q, prem_d;
  logic [WIDTH-1:0] shq_q, shq_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic [WIDTH:0]   step_in;
  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  // The dividend magnitude shifts out of shq MSB-first while quotient bits shift in.
  assign step_in = {prem_q, shq_q[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (step_in),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    prem_d  = prem_q;
    shq_d   = shq_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          negq_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          negr_d = is_signed & dividend[WIDTH-1];
          shq_d  = cond_neg(dividend, is_signed & dividend[WIDTH-1]);
          dvsr_d = cond_neg(divisor, is_signed & divisor[WIDTH-1]);
          prem_d = '0;
          cnt_d  = '0;
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        prem_d = step_rem;
        shq_d  = {shq_q[WIDTH-2:0], step_qbit};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Most-negative / -1 needs no special case: magnitude 2^(W-1) reads back as most-negative.
        quot_d  = cond_neg(shq_q, negq_q);
        rem_d   = cond_neg(prem_q, negr_q);
        dbz_d   = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Working datapath is only meaningful while the FSM is in CALC/FIX.
  always_ff @(posedge clk) begin
    prem_q <= prem_d;
    shq_q  <= shq_d;
    dvsr_q <= dvsr_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
  end

  assign busy        = (state_q == CALC) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and randomized bench for sequential_divider against an arithmetic reference model.
module tb_sequential_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;

  sequential_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic from the divide rules.
  function automatic void model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    z  = 1'b0;
    if (b == 0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else if (sgn) begin
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
        q = a;
        r = '0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    is_signed = ~sgn;
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic sgn, input logic [W-1:0] a,
                              input logic [W-1:0] b);
    logic [W-1:0] eq, er;
    logic         ez;
    model(sgn, a, b, eq, er, ez);
    chk({tag, ".q"}, 64'(quotient), 64'(eq));
    chk({tag, ".r"}, 64'(remainder), 64'(er));
    chk({tag, ".dbz"}, 64'(div_by_zero), 64'(ez));
  endtask

  task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit inject);
    int lat, exp_lat;
    launch(sgn, a, b);
    exp_lat = (b == 0) ? 0 : W + 1;
    if (inject && b != 0) begin
      is_signed = $urandom;
      dividend  = $urandom;
      divisor   = $urandom_range(1, 5);
      start     = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      exp_lat = exp_lat - 1;
    end
    wait_done(lat);
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    check_result(tag, sgn, a, b);
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    int lat, dc;
    logic [W-1:0] a, b;
    logic sgn;

    // Reset state
    @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'(0));
    chk("rst.done", 64'(done), 64'(0));
    chk("rst.q", 64'(quotient), 64'(0));
    chk("rst.r", 64'(remainder), 64'(0));
    chk("rst.dbz", 64'(div_by_zero), 64'(0));
    rst = 1'b0;

    // Directed cases
    launch(1'b0, 32'd100, 32'd7);
    chk("u100_7.busy", 64'(busy), 64'(1));
    wait_done(lat);
    chk("u100_7.lat", 64'(lat), 64'(W + 1));
    chk("u100_7.q", 64'(quotient), 64'(14));
    chk("u100_7.r", 64'(remainder), 64'(2));
    chk("u100_7.dbz", 64'(div_by_zero), 64'(0));
    chk("u100_7.busy_done", 64'(busy), 64'(0));
    @(posedge clk);
    #1;
    chk("u100_7.hold", 64'(quotient), 64'(14));

    run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("s-7_2.qc", 64'(quotient), 64'(32'hFFFF_FFFD));
    chk("s-7_2.rc", 64'(remainder), 64'(32'hFFFF_FFFF));
    run_div("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    chk("s7_-2.qc", 64'(quotient), 64'(32'hFFFF_FFFD));
    chk("s7_-2.rc", 64'(remainder), 64'(1));
    run_div("u5_0", 1'b0, 32'd5, 32'd0, 1'b0);
    chk("u5_0.qc", 64'(quotient), 64'(32'hFFFF_FFFF));
    run_div("s5_0", 1'b1, 32'd5, 32'd0, 1'b0);
    chk("s5_0.rc", 64'(remainder), 64'(5));
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("s_ovf.qc", 64'(quotient), 64'(32'h8000_0000));
    run_div("u_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("u_ovf.rc", 64'(remainder), 64'(32'h8000_0000));
    run_div("u100_7b", 1'b0, 32'd100, 32'd7, 1'b0);

    // Abort: start at edge 0, ignored start at edge 10, reset just after edge 20
    launch(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    is_signed = 1'b0;
    dividend  = 32'd9;
    divisor   = 32'd3;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("abort.busy10", 64'(busy), 64'(1));
    repeat (10) @(posedge clk);
    #1;
    dc  = done_cnt;
    rst = 1'b1;
    #1;
    chk("abort.busy", 64'(busy), 64'(0));
    chk("abort.done", 64'(done), 64'(0));
    chk("abort.q", 64'(quotient), 64'(0));
    chk("abort.r", 64'(remainder), 64'(0));
    chk("abort.dbz", 64'(div_by_zero), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort.nodone", 64'(done_cnt), 64'(dc));

    // First start after reset release is taken on the very next edge
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_div("post_rst", 1'b0, 32'd9, 32'd3, 1'b0);
    chk("post_rst.qc", 64'(quotient), 64'(3));
    chk("post_rst.rc", 64'(remainder), 64'(0));

    // Back-to-back: new start issued in the DONE cycle
    launch(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done(lat);
    chk("b2b.lat1", 64'(lat), 64'(W + 1));
    check_result("b2b.first", 1'b1, 32'hFFFF_FF9C, 32'd7);
    launch(1'b0, 32'd1000, 32'd33);
    chk("b2b.busy", 64'(busy), 64'(1));
    chk("b2b.hold_q", 64'(quotient), 64'(32'hFFFF_FFF2));
    chk("b2b.hold_r", 64'(remainder), 64'(32'hFFFF_FFFE));
    wait_done(lat);
    chk("b2b.lat2", 64'(lat), 64'(W + 1));
    check_result("b2b.second", 1'b0, 32'd1000, 32'd33);
    @(posedge clk);
    #1;

    // Randomized operations, some with a start pulse injected while busy
    for (int i = 0; i < 24; i++) begin
      sgn = $urandom;
      a   = $urandom;
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = $urandom_range(1, 9);
        2:       b = -($urandom_range(1, 9));
        3:       b = a;
        4:       b = $urandom >> $urandom_range(0, 30);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = {1'b1, {(W-1){1'b0}}};
      run_div($sformatf("rnd%0d", i), sgn, a, b, bit'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
